rom_boot_loader: RTL and testbench

Boot-time copier that sits directly downstream of the synchronous program ROM. It reads the ROM image byte by byte, checks the 4-byte "ASRM" magic header, and writes every byte into main RAM through a valid/ready write port. The CPU is held in reset until the copy completes successfully.

---
 rtl/rom_boot_loader_pkg.sv | 31 +++
 rtl/rom_boot_loader.sv | 107 ++++++++++
 tb/tb_rom_boot_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_boot_loader_pkg.sv
// Shared definitions for the ROM-to-RAM boot copier: FSM states and the
// "ASRM" image magic header.
package rom_boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] MAGIC_0   = 8'h41;
    localparam logic [7:0] MAGIC_1   = 8'h53;
    localparam logic [7:0] MAGIC_2   = 8'h52;
    localparam logic [7:0] MAGIC_3   = 8'h4D;
    localparam int unsigned MAGIC_LEN = 4;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = MAGIC_0;
            2'd1:    b = MAGIC_1;
            2'd2:    b = MAGIC_2;
            default: b = MAGIC_3;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rom_boot_loader.sv
// Boot copier: streams the ROM image into RAM over a valid/ready port,
// validating the magic header and holding the CPU in reset until done.
module rom_boot_loader
    import rom_boot_loader_pkg::*;
#(
    parameter int ROM_ADDR_W  = 7,
    parameter int DATA_W      = 8,
    parameter int RAM_ADDR_W  = 16,
    parameter int RAM_BASE    = 0,
    parameter int LENGTH      = 116,
    parameter bit CHECK_MAGIC = 1'b1,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_reset_hold,
    output logic                  rom_enable,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic                  ram_wr_valid,
    output logic [RAM_ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0]     ram_wr_data,
    input  logic                  ram_wr_ready
);

    localparam int CNT_W = ROM_ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);

    state_t                state, state_next;
    logic [CNT_W-1:0]      count, count_next;
    logic [ROM_ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0]     data_q, data_next;
    logic                  first_q;
    logic                  magic_bad;
    logic                  go;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            first_q <= 1'b1;
        end else begin
            state   <= state_next;
            count   <= count_next;
            addr_q  <= addr_next;
            data_q  <= data_next;
            first_q <= 1'b0;
        end
    end

    assign magic_bad = CHECK_MAGIC && (count < CNT_W'(MAGIC_LEN)) &&
                       (rom_data != DATA_W'(magic_byte(count[1:0])));

    // rom_addr is registered so it holds its value outside FETCH; it is
    // loaded with the upcoming counter value on every entry to FETCH.
    always_comb begin
        state_next = state;
        count_next = count;
        addr_next  = addr_q;
        data_next  = data_q;
        go         = 1'b0;
        case (state)
            S_IDLE:  go = start || (AUTO_START && first_q);
            S_FETCH: state_next = S_LATCH;
            S_LATCH: begin
                data_next  = rom_data;
                state_next = magic_bad ? S_ERROR : S_WRITE;
            end
            S_WRITE: begin
                if (ram_wr_ready) begin
                    if (count == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
                        count_next = count + 1'b1;
                        addr_next  = ROM_ADDR_W'(count + 1'b1);
                        state_next = S_FETCH;
                    end
                end
            end
            S_DONE, S_ERROR: go = start;
            default: state_next = S_IDLE;
        endcase
        if (go) begin
            state_next = S_FETCH;
            count_next = '0;
            addr_next  = '0;
        end
    end

    assign busy           = (state == S_FETCH) || (state == S_LATCH) || (state == S_WRITE);
    assign done           = (state == S_DONE);
    assign error          = (state == S_ERROR);
    assign cpu_reset_hold = (state != S_DONE);
    assign rom_enable     = (state == S_FETCH) || (state == S_LATCH);
    assign rom_addr       = addr_q;
    assign ram_wr_valid   = (state == S_WRITE);
    assign ram_wr_addr    = (state == S_WRITE) ?
                            RAM_ADDR_W'(RAM_BASE) + RAM_ADDR_W'(count) : '0;
    assign ram_wr_data    = (state == S_WRITE) ? data_q : '0;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Self-checking bench: two copier instances (default and full-ROM/offset/
// no-magic variants) with ROM models, scoreboards and a copy reference model.
module tb_rom_boot_loader;

    localparam logic [7:0] TB_MAGIC [4] = '{8'h41, 8'h53, 8'h52, 8'h4D};

    logic clk;
    int compared = 0;
    int mismatched = 0;

    logic rst1, start1, busy1, done1, err1, hold1, ren1, wv1, rdy1;
    logic [6:0] raddr1;
    logic [7:0] rdata1, wd1;
    logic [15:0] wa1;
    logic rst2, start2, busy2, done2, err2, hold2, ren2, wv2, rdy2;
    logic [6:0] raddr2;
    logic [7:0] rdata2, wd2;
    logic [15:0] wa2, last_a2;

    logic [7:0] rom1 [128];
    logic [7:0] rom2 [128];
    int wr1 = 0, wr2 = 0, burst2 = 0;
    bit rnd2 = 0;

    rom_boot_loader dut1 (
        .clk(clk), .reset(rst1), .start(start1), .busy(busy1), .done(done1),
        .error(err1), .cpu_reset_hold(hold1), .rom_enable(ren1), .rom_addr(raddr1),
        .rom_data(rdata1), .ram_wr_valid(wv1), .ram_wr_addr(wa1), .ram_wr_data(wd1),
        .ram_wr_ready(rdy1)
    );

    rom_boot_loader #(.LENGTH(128), .CHECK_MAGIC(1'b0), .RAM_BASE(256), .AUTO_START(1'b0)) dut2 (
        .clk(clk), .reset(rst2), .start(start2), .busy(busy2), .done(done2),
        .error(err2), .cpu_reset_hold(hold2), .rom_enable(ren2), .rom_addr(raddr2),
        .rom_data(rdata2), .ram_wr_valid(wv2), .ram_wr_addr(wa2), .ram_wr_data(wd2),
        .ram_wr_ready(rdy2)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROMs: one-cycle latency, zero when not enabled.
    always @(posedge clk) rdata1 <= ren1 ? rom1[raddr1] : 8'h00;
    always @(posedge clk) rdata2 <= ren2 ? rom2[raddr2] : 8'h00;

    // Reference model: bytes are copied in order until the first header mismatch.
    function automatic int n_writes(input logic [7:0] img [128], input int len,
                                    input bit chk, output bit err);
        err = 0;
        for (int i = 0; i < len; i++) begin
            if (chk && i < 4 && img[i] != TB_MAGIC[i]) begin
                err = 1;
                return i;
            end
        end
        return len;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (burst2 > 0) begin
                rdy2 = 0;
                burst2--;
            end else begin
                rdy2 = rnd2 ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst1 && wv1 && rdy1) begin
                compared++;
                if (wr1 >= 116 || wa1 !== 16'(wr1) || wd1 !== rom1[wr1[6:0]]) begin
                    mismatched++;
                    $display("FAIL write1[%0d]: got a=%h d=%h, need a=%h d=%h",
                             wr1, wa1, wd1, 16'(wr1), rom1[wr1[6:0]]);
                end
                wr1++;
            end
        end
    end

    initial begin
        bit p2;
        logic [15:0] pa2;
        logic [7:0] pd2;
        p2 = 0;
        forever begin
            @(negedge clk);
            if (rst2) begin
                p2 = 0;
            end else begin
                if (p2) begin
                    compared++;
                    if (wv2 !== 1'b1 || wa2 !== pa2 || wd2 !== pd2) begin
                        mismatched++;
                        $display("FAIL stall_stable2: got v=%b a=%h d=%h, need v=1 a=%h d=%h",
                                 wv2, wa2, wd2, pa2, pd2);
                    end
                end
                if (wv2 && rdy2) begin
                    compared++;
                    if (wr2 >= 128 || wa2 !== 16'(256 + wr2) || wd2 !== rom2[wr2[6:0]]) begin
                        mismatched++;
                        $display("FAIL write2[%0d]: got a=%h d=%h, need a=%h d=%h",
                                 wr2, wa2, wd2, 16'(256 + wr2), rom2[wr2[6:0]]);
                    end
                    last_a2 = wa2;
                    wr2++;
                end
                p2 = wv2 && !rdy2;
                pa2 = wa2;
                pd2 = wd2;
            end
        end
    end

    task automatic pulse_start1();
        @(posedge clk);
        #2 start1 = 1;
        @(posedge clk);
        #1 start1 = 0;
    endtask

    task automatic test_reset();
        logic [37:0] got, need;
        rst1 = 1; rst2 = 1; start1 = 0; start2 = 0; rdy1 = 1;
        repeat (3) @(posedge clk);
        #1;
        need = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h0, 1'b0, 16'h0, 8'h0};
        got = {busy1, done1, err1, hold1, ren1, raddr1, wv1, wa1, wd1};
        compared++;
        if (got !== need) begin
            mismatched++;
            $display("FAIL reset1: got %h need %h", got, need);
        end
        got = {busy2, done2, err2, hold2, ren2, raddr2, wv2, wa2, wd2};
        compared++;
        if (got !== need) begin
            mismatched++;
            $display("FAIL reset2: got %h need %h", got, need);
        end
    endtask

    task automatic test_autostart();
        int k;
        bit e;
        int n;
        n = n_writes(rom1, 116, 1, e);
        wr1 = 0;
        @(posedge clk);
        #2 rst1 = 0;
        @(posedge clk);
        for (k = 1; k <= 500; k++) begin
            @(posedge clk);
            #1;
            if (done1) break;
        end
        compared++;
        if (k != 348) begin
            mismatched++;
            $display("FAIL auto_latency: got %0d edges need 348", k);
        end
        #5;
        compared++;
        if (wr1 != n || hold1 !== 1'b0 || err1 !== 1'b0) begin
            mismatched++;
            $display("FAIL auto_copy: got writes=%0d hold=%b err=%b need %0d/0/0", wr1, hold1, err1, n);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        wr1 = 0;
        @(posedge clk);
        #2 start1 = 1;
        @(posedge clk);
        #1 start1 = 0;
        compared++;
        if (hold1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            mismatched++;
            $display("FAIL restart_hold: got hold=%b busy=%b done=%b need 1/1/0", hold1, busy1, done1);
        end
        for (k = 1; k <= 500; k++) begin
            @(posedge clk);
            #1;
            start1 = (k == 100 || k == 101 || k == 202);
            if (done1) break;
        end
        start1 = 0;
        compared++;
        if (k != 348) begin
            mismatched++;
            $display("FAIL busy_start_latency: got %0d edges need 348", k);
        end
        #5;
        compared++;
        if (wr1 != 116) begin
            mismatched++;
            $display("FAIL busy_start_writes: got %0d need 116", wr1);
        end
    endtask

    task automatic test_magic_error();
        int reads;
        bit e;
        int n;
        rom1[2] = 8'h00;
        n = n_writes(rom1, 116, 1, e);
        for (int pass = 0; pass < 2; pass++) begin
            wr1 = 0;
            pulse_start1();
            for (int k = 0; k < 60 && !err1; k++) begin
                @(posedge clk);
                #1;
            end
            #5;
            compared++;
            if (err1 !== e || done1 !== 1'b0 || hold1 !== 1'b1 || wr1 != n) begin
                mismatched++;
                $display("FAIL magic_err[%0d]: got err=%b done=%b hold=%b writes=%0d need %b/0/1/%0d",
                         pass, err1, done1, hold1, wr1, e, n);
            end
            reads = 0;
            repeat (10) begin
                @(negedge clk);
                if (ren1 || busy1) reads++;
            end
            compared++;
            if (reads != 0) begin
                mismatched++;
                $display("FAIL magic_quiet[%0d]: got %0d active cycles need 0", pass, reads);
            end
        end
        rom1[2] = TB_MAGIC[2];
        wr1 = 0;
        pulse_start1();
        for (int k = 0; k < 500 && !done1; k++) begin
            @(posedge clk);
            #1;
        end
        #5;
        compared++;
        if (done1 !== 1'b1 || err1 !== 1'b0 || wr1 != 116) begin
            mismatched++;
            $display("FAIL magic_recover: got done=%b err=%b writes=%0d need 1/0/116", done1, err1, wr1);
        end
    endtask

    task automatic test_reset_midcopy();
        int k;
        logic [37:0] got, need;
        bit seen;
        wr1 = 0;
        seen = 0;
        @(posedge clk);
        #2 start1 = 1;
        @(posedge clk);
        #1 start1 = 0;
        for (int j = 0; j < 500; j++) begin
            @(posedge clk);
            #2;
            if (wv1 && wa1 == 16'd40) begin
                seen = 1;
                break;
            end
        end
        rst1 = 1;
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL midcopy_reach: got no write at byte 40 need one");
        end
        @(posedge clk);
        #1;
        need = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h0, 1'b0, 16'h0, 8'h0};
        got = {busy1, done1, err1, hold1, ren1, raddr1, wv1, wa1, wd1};
        compared++;
        if (got !== need) begin
            mismatched++;
            $display("FAIL midcopy_reset: got %h need %h", got, need);
        end
        wr1 = 0;
        rst1 = 0;
        @(posedge clk);
        for (k = 1; k <= 500; k++) begin
            @(posedge clk);
            #1;
            if (done1) break;
        end
        #5;
        compared++;
        if (k != 348 || wr1 != 116) begin
            mismatched++;
            $display("FAIL midcopy_restart: got edges=%0d writes=%0d need 348/116", k, wr1);
        end
    endtask

    task automatic test_full_rom_stall();
        bit e;
        int n;
        n = n_writes(rom2, 128, 0, e);
        @(posedge clk);
        #2 rst2 = 0;
        repeat (5) @(posedge clk);
        #1;
        compared++;
        if (busy2 !== 1'b0 || ren2 !== 1'b0 || hold2 !== 1'b1) begin
            mismatched++;
            $display("FAIL no_autostart: got busy=%b ren=%b hold=%b need 0/0/1", busy2, ren2, hold2);
        end
        rnd2 = 1;
        wr2 = 0;
        #1 start2 = 1;
        @(posedge clk);
        #1 start2 = 0;
        for (int k = 1; k < 3000 && !done2; k++) begin
            @(posedge clk);
            #1;
            if (k == 20 || k == 200) burst2 = 5;
        end
        #5;
        compared++;
        if (done2 !== 1'b1 || err2 !== e || hold2 !== 1'b0) begin
            mismatched++;
            $display("FAIL full_flags: got done=%b err=%b hold=%b need 1/%b/0", done2, err2, hold2, e);
        end
        compared++;
        if (wr2 != n || last_a2 !== 16'h017F) begin
            mismatched++;
            $display("FAIL full_count: got writes=%0d last=%h need %0d/017f", wr2, last_a2, n);
        end
        rnd2 = 0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            rom1[i] = 8'($urandom);
            rom2[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            rom1[i] = TB_MAGIC[i];
            rom2[i] = TB_MAGIC[i];
        end
        rom2[2] = 8'h00;
        rdy2 = 1;
        test_reset();
        test_autostart();
        test_back_to_back();
        test_magic_error();
        test_reset_midcopy();
        test_full_rom_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
